rx_axis_fifo: RTL and testbench

RX_AXIS_FIFO -- requirements
Module: rx_axis_fifo

---
 rtl/rx_axis_fifo.sv | 108 ++++++++++
 tb/tb_rx_axis_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rx_axis_fifo.sv
// UART receive byte FIFO presenting bytes as an AXI-Stream master with per-packet tlast.
// Build option: define PARITY_ERR_KEEP_EN to buffer parity-failed bytes flagged on tuser.
module rx_axis_fifo #(
   parameter int DEPTH     = 16,
   parameter int DATA_BITS = 8,
   parameter int PKT_LEN   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_BITS-1:0]     rx_data,
   input  logic                     rx_valid,
   input  logic                     parity_error,
   output logic [DATA_BITS-1:0]     m_axis_tdata,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic                     m_axis_tuser,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   input  logic                     clr_ovf,
   output logic [7:0]               drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam int EW = DATA_BITS + 2;

   // Each entry is {tlast, tuser, data}.
   logic [EW-1:0]        r_mem [DEPTH];
   logic [AW:0]          r_wr_ptr;
   logic [AW:0]          r_rd_ptr;
   logic [CW-1:0]        r_pkt_cnt;
   logic                 r_overflow;
   logic [7:0]           r_drop_cnt;

   logic [AW:0]          w_level;
   logic                 w_empty;
   logic                 w_full;
   logic                 w_push_req;
   logic                 w_tuser_in;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_drop;
   logic                 w_last_in;
   logic [EW-1:0]        w_head;

`ifdef PARITY_ERR_KEEP_EN
   assign w_push_req = rx_valid | parity_error;
   assign w_tuser_in = parity_error;
`else
   logic w_unused_pe;
   assign w_unused_pe = parity_error;
   assign w_push_req  = rx_valid;
   assign w_tuser_in  = 1'b0;
`endif

   assign w_level   = r_wr_ptr - r_rd_ptr;
   assign w_empty   = (w_level == '0);
   assign w_full    = (w_level == (AW+1)'(DEPTH));
   assign w_pop     = ~w_empty & m_axis_tready;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign w_push    = w_push_req & (~w_full | w_pop);
   assign w_drop    = w_push_req & w_full & ~w_pop;
   assign w_last_in = (r_pkt_cnt == CW'(PKT_LEN - 1));
   assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {w_last_in, w_tuser_in, rx_data};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_pkt_cnt  <= '0;
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr  <= r_wr_ptr + 1'b1;
            r_pkt_cnt <= w_last_in ? '0 : r_pkt_cnt + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         // A fresh drop wins over a clear arriving in the same cycle.
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clr_ovf) begin
            r_overflow <= 1'b0;
         end
         if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
      end
   end

   // Head fields are gated by tvalid so an empty or reset FIFO shows zeros.
   assign m_axis_tvalid = ~w_empty;
   assign m_axis_tdata  = m_axis_tvalid ? w_head[DATA_BITS-1:0] : '0;
   assign m_axis_tuser  = m_axis_tvalid & w_head[DATA_BITS];
   assign m_axis_tlast  = m_axis_tvalid & w_head[DATA_BITS+1];
   assign level         = w_level;
   assign overflow      = r_overflow;
   assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_rx_axis_fifo.sv
// Randomized scoreboard bench for rx_axis_fifo (DEPTH=16, PKT_LEN=4) with a queue reference model.
module tb_rx_axis_fifo;
   localparam int DEPTH = 16;
   localparam int DW    = 8;
   localparam int PLEN  = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [DW-1:0]   rx_data = '0;
   logic            rx_valid = 1'b0;
   logic            parity_error = 1'b0;
   logic [DW-1:0]   m_axis_tdata;
   logic            m_axis_tvalid;
   logic            m_axis_tready = 1'b0;
   logic            m_axis_tlast;
   logic            m_axis_tuser;
   logic [LW-1:0]   level;
   logic            overflow;
   logic            clr_ovf = 1'b0;
   logic [7:0]      drop_cnt;

   rx_axis_fifo #(.DEPTH(DEPTH), .DATA_BITS(DW), .PKT_LEN(PLEN)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .parity_error(parity_error), .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .level(level), .overflow(overflow), .clr_ovf(clr_ovf), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO contents as a queue of {tlast,tuser,data}, plus counters.
   logic [DW+1:0] exp_q[$];
   int            m_pkt  = 0;
   bit            m_ovf  = 0;
   int            m_drop = 0;

   always @(negedge clk) begin
      bit push_req, tuser_in, pop, full;
      if (!rst) begin
         exp_q.delete();
         m_pkt = 0; m_ovf = 0; m_drop = 0;
         chk("rst_tvalid", m_axis_tvalid, 0);
         chk("rst_level",  level, 0);
         chk("rst_tdata",  m_axis_tdata, 0);
         chk("rst_tlast",  m_axis_tlast, 0);
         chk("rst_tuser",  m_axis_tuser, 0);
         chk("rst_ovf",    overflow, 0);
         chk("rst_drop",   drop_cnt, 0);
      end else begin
         chk("tvalid", m_axis_tvalid, (exp_q.size() != 0) ? 1 : 0);
         chk("level", level, exp_q.size());
         chk("overflow", overflow, m_ovf);
         chk("drop_cnt", drop_cnt, m_drop);
         if (m_axis_tvalid && exp_q.size() != 0) begin
            chk("tdata", m_axis_tdata, exp_q[0][DW-1:0]);
            chk("tuser", m_axis_tuser, exp_q[0][DW]);
            chk("tlast", m_axis_tlast, exp_q[0][DW+1]);
         end
         // Effect of the coming rising edge.
`ifdef PARITY_ERR_KEEP_EN
         push_req = rx_valid || parity_error;
         tuser_in = parity_error;
`else
         push_req = rx_valid;
         tuser_in = 0;
`endif
         full = (exp_q.size() == DEPTH);
         pop  = (exp_q.size() != 0) && m_axis_tready;
         if (pop) void'(exp_q.pop_front());
         if (push_req && (!full || pop)) begin
            exp_q.push_back({(m_pkt == PLEN - 1), tuser_in, rx_data});
            m_pkt = (m_pkt + 1) % PLEN;
         end else if (push_req) begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
         end
         if (clr_ovf && !(push_req && full && !pop)) m_ovf = 0;
      end
   end

   // Drives one cycle of inputs; they change 1 time unit after the rising edge.
   task automatic cyc(input bit v, input bit pe, input logic [DW-1:0] d, input bit rdy, input bit clr);
      rx_valid = v; parity_error = pe; rx_data = d; m_axis_tready = rdy; clr_ovf = clr;
      @(posedge clk); #1;
   endtask

   task automatic idle(input bit rdy);
      cyc(0, 0, '0, rdy, 0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 64 && exp_q.size() != 0; i++) idle(1);
      chk("drain_done", exp_q.size(), 0);
   endtask

   initial begin
      #1;
      do_reset();

      // Single byte through an empty FIFO.
      cyc(1, 0, 8'hA5, 1, 0);
      chk("a5_level", level, 1);
      chk("a5_tdata", m_axis_tdata, 8'hA5);
      idle(1);
      chk("a5_empty", level, 0);

      // 17 bytes into a stalled FIFO: one dropped.
      do_reset();
      for (int i = 0; i < 17; i++) cyc(1, 0, 8'(8'h10 + i), 0, 0);
      chk("ovf_level", level, 16);
      chk("ovf_flag", overflow, 1);
      chk("ovf_drop", drop_cnt, 1);
      drain();
      cyc(0, 0, '0, 1, 1);
      chk("clr_ovf", overflow, 0);
      chk("clr_keeps_drop", drop_cnt, 1);

      // tlast every PKT_LEN bytes.
      do_reset();
      for (int i = 0; i < 8; i++) cyc(1, 0, 8'(i), 0, 0);
      drain();

      // Full FIFO with simultaneous push and pop.
      do_reset();
      for (int i = 0; i < 16; i++) cyc(1, 0, 8'(8'h40 + i), 0, 0);
      cyc(1, 0, 8'hEE, 1, 0);
      chk("full_pp_level", level, 16);
      chk("full_pp_ovf", overflow, 0);
      drain();

      // Clear and new overflow in the same cycle leaves it set.
      for (int i = 0; i < 16; i++) cyc(1, 0, 8'(i), 0, 0);
      cyc(1, 0, 8'h77, 0, 1);
      chk("clr_vs_drop", overflow, 1);
      drain();

      // Parity-error strobe.
      do_reset();
      cyc(0, 1, 8'h3C, 0, 0);
`ifdef PARITY_ERR_KEEP_EN
      chk("pe_level", level, 1);
      chk("pe_tuser", m_axis_tuser, 1);
      chk("pe_tdata", m_axis_tdata, 8'h3C);
`else
      chk("pe_level", level, 0);
`endif
      cyc(1, 1, 8'h5A, 0, 0);
      drain();

      // Reset mid-operation, then a fresh packet.
      for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h80 + i), 0, 0);
      rst = 1'b0; #1;
      chk("midrst_tvalid", m_axis_tvalid, 0);
      chk("midrst_level", level, 0);
      chk("midrst_ovf", overflow, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'hC0 + i), 0, 0);
      drain();

      // drop_cnt saturation.
      for (int i = 0; i < 300; i++) cyc(1, 0, 8'(i), 0, 0);
      chk("drop_sat", drop_cnt, 255);
      drain();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 10),
             8'($urandom_range(0, 255)), ($urandom_range(0, 99) < 45),
             ($urandom_range(0, 99) < 3));
         if ($urandom_range(0, 999) == 0) do_reset();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
